pc_sequencer: RTL and testbench

//  Next-PC generator driving the fetch stage's PC input (other end of the PC->IF interface).

---
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module      : pc_sequencer
//  Description : Next-PC generator for the fetch stage. Owns the fetch PC, EPC,
//                the kernel bit, pending-interrupt state and pipeline flushes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] ILLOP_ADDR = 32'h8000_0004,
    parameter logic [31:0] XADR_ADDR  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic        eret,
    input  logic        illop,
    input  logic [31:0] id_pc,
    input  logic        irq,
    output logic [31:0] PC,
    output logic [31:0] epc,
    output logic        kernel,
    output logic        flush_if,
    output logic        flush_id,
    output logic        irq_ack
);

    // Interrupt state is {kernel, irq_pend}
    localparam logic [1:0] c_ST_USER      = 2'b00;
    localparam logic [1:0] c_ST_USER_PEND = 2'b01;
    localparam logic [1:0] c_ST_KERNEL    = 2'b10;
    localparam logic [1:0] c_ST_KERN_PEND = 2'b11;

    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic [31:0] r_pc_prev;
    logic        r_irq_pend;
    logic        r_flush_hold;

    logic [1:0]  w_state;
    logic        w_irq_want;
    logic [31:0] w_pc_next;
    logic [31:0] w_epc_next;
    logic        w_redirect;
    logic        w_take;
    logic        w_irq_pend_next;

    assign w_state = {r_pc[31], r_irq_pend};

    // User-mode request: live level in USER, latched request in USER_PEND
    always_comb begin
        w_irq_want = 1'b0;
        case (w_state)
            c_ST_USER:      w_irq_want = irq;
            c_ST_USER_PEND: w_irq_want = 1'b1;
            c_ST_KERNEL:    w_irq_want = 1'b0;
            c_ST_KERN_PEND: w_irq_want = 1'b0;
            default:        w_irq_want = 1'b0;
        endcase
    end

    always_comb begin
        w_pc_next  = r_pc + 32'd4;
        w_epc_next = r_epc;
        w_redirect = 1'b1;
        w_take     = 1'b0;
        if (branch_taken) begin
            w_pc_next = branch_target;
        end else if (illop) begin
            w_pc_next  = ILLOP_ADDR;
            w_epc_next = id_pc + 32'd4;
        end else if (eret) begin
            w_pc_next = r_epc;
        end else if (jr) begin
            w_pc_next = jr_target;
        end else if (jump) begin
            w_pc_next = jump_target;
        end else if (stall) begin
            w_pc_next  = r_pc;
            w_redirect = 1'b0;
        end else if (w_irq_want && !r_flush_hold) begin
            // Clean cycle: the instruction IF is presenting becomes the resume point
            w_pc_next  = XADR_ADDR;
            w_epc_next = r_pc_prev;
            w_take     = 1'b1;
        end else begin
            w_redirect = 1'b0;
        end
    end

    // An un-taken request is latched; a take consumes it
    assign w_irq_pend_next = w_take ? 1'b0 : (r_irq_pend | irq);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_epc        <= 32'h0000_0000;
            r_pc_prev    <= RESET_PC;
            r_irq_pend   <= 1'b0;
            r_flush_hold <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_epc        <= w_epc_next;
            r_pc_prev    <= r_pc;
            r_irq_pend   <= w_irq_pend_next;
            r_flush_hold <= w_redirect;
        end
    end

    assign PC       = r_pc;
    assign epc      = r_epc;
    assign kernel   = r_pc[31];
    assign flush_if = (w_redirect | r_flush_hold) & ~reset;
    assign flush_id = branch_taken & ~reset;
    assign irq_ack  = w_take & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed self-checking bench for pc_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, branch_taken, jump, jr, eret, illop, irq;
    logic [31:0] branch_target, jump_target, jr_target, id_pc;
    logic [31:0] PC, epc;
    logic        kernel, flush_if, flush_id, irq_ack;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jr(jr), .jump_target(jump_target), .jr_target(jr_target),
        .eret(eret), .illop(illop), .id_pc(id_pc), .irq(irq),
        .PC(PC), .epc(epc), .kernel(kernel),
        .flush_if(flush_if), .flush_id(flush_id), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    // Step just past the next rising edge; inputs change here, checks follow after #1
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; branch_taken = 0; jump = 0; jr = 0; eret = 0; illop = 0;
        branch_target = 0; jump_target = 0; jr_target = 0; id_pc = 0;
    endtask

    initial begin
        clear_inputs();
        irq   = 0;
        reset = 1;

        // Reset for two cycles, then count up from zero
        tick(); tick();
        #1 check("rst_flush_if", {31'd0, flush_if}, 32'd0);
        reset = 0;
        #1;
        check("rst_pc", PC, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_kernel", {31'd0, kernel}, 32'd0);
        check("rst_irq_ack", {31'd0, irq_ack}, 32'd0);
        tick(); check("seq_pc4", PC, 32'h4);
        tick(); check("seq_pc8", PC, 32'h8);
        tick(); check("seq_pcC", PC, 32'hC);
        check("seq_flush_if", {31'd0, flush_if}, 32'd0);
        tick(); check("seq_pc10", PC, 32'h10);

        // Stall two cycles holds PC
        stall = 1;
        #1 check("stall_flush_if", {31'd0, flush_if}, 32'd0);
        tick(); check("stall_pc_a", PC, 32'h10);
        tick(); check("stall_pc_b", PC, 32'h10);
        stall = 0;
        tick(); check("stall_release", PC, 32'h14);

        // Branch beats jump and stall; flush_id one cycle, flush_if two
        branch_taken = 1; branch_target = 32'h100;
        jump = 1; jump_target = 32'h200; stall = 1;
        #1;
        check("br_flush_id", {31'd0, flush_id}, 32'd1);
        check("br_flush_if", {31'd0, flush_if}, 32'd1);
        tick(); clear_inputs(); #1;
        check("br_pc", PC, 32'h100);
        check("br_flush_if_2nd", {31'd0, flush_if}, 32'd1);
        check("br_flush_id_off", {31'd0, flush_id}, 32'd0);
        tick(); check("br_flush_if_end", {31'd0, flush_if}, 32'd0);
        check("br_pc_next", PC, 32'h104);

        // Illegal op vectors to kernel; irq while in kernel is only latched
        illop = 1; id_pc = 32'h24;
        #1 check("ill_flush_if", {31'd0, flush_if}, 32'd1);
        tick(); clear_inputs(); #1;
        check("ill_pc", PC, 32'h8000_0004);
        check("ill_epc", epc, 32'h28);
        check("ill_kernel", {31'd0, kernel}, 32'd1);
        irq = 1;
        #1 check("kern_no_ack_a", {31'd0, irq_ack}, 32'd0);
        tick(); irq = 0; #1;
        check("kern_pc", PC, 32'h8000_0008);
        check("kern_no_ack_b", {31'd0, irq_ack}, 32'd0);

        // eret returns to user; pending irq waits out the flush window
        eret = 1;
        #1;
        check("eret_flush_if", {31'd0, flush_if}, 32'd1);
        check("eret_no_ack", {31'd0, irq_ack}, 32'd0);
        tick(); clear_inputs(); #1;
        check("eret_pc", PC, 32'h28);
        check("eret_kernel", {31'd0, kernel}, 32'd0);
        check("eret_flush_if_2nd", {31'd0, flush_if}, 32'd1);
        check("eret_no_ack_hold", {31'd0, irq_ack}, 32'd0);
        // First clean cycle: PC=0x2C, IF presenting 0x28, which becomes EPC
        tick();
        check("irq_take_pc", PC, 32'h2C);
        check("irq_ack", {31'd0, irq_ack}, 32'd1);
        check("irq_flush_if", {31'd0, flush_if}, 32'd1);
        tick();
        check("irq_vec_pc", PC, 32'h8000_0008);
        check("irq_epc", epc, 32'h28);
        check("irq_ack_pulse", {31'd0, irq_ack}, 32'd0);
        check("irq_kernel", {31'd0, kernel}, 32'd1);

        // Back to user, then illop and irq together: illop wins, irq stays pending
        eret = 1;
        tick(); clear_inputs(); #1;
        check("eret2_pc", PC, 32'h28);
        tick(); check("eret2_no_ack", {31'd0, irq_ack}, 32'd0);
        illop = 1; id_pc = 32'h40; irq = 1;
        #1 check("ill_irq_no_ack", {31'd0, irq_ack}, 32'd0);
        tick(); clear_inputs(); irq = 0; #1;
        check("ill_irq_pc", PC, 32'h8000_0004);
        check("ill_irq_epc", epc, 32'h44);

        // Reset during flush window with an IRQ pending drops both
        reset = 1;
        #1;
        check("rst_mid_flush_if", {31'd0, flush_if}, 32'd0);
        check("rst_mid_ack", {31'd0, irq_ack}, 32'd0);
        tick(); reset = 0; #1;
        check("rst2_pc", PC, 32'h0);
        check("rst2_flush_if", {31'd0, flush_if}, 32'd0);
        check("rst2_no_ack", {31'd0, irq_ack}, 32'd0);
        check("rst2_epc", epc, 32'h0);

        // jr beats jump; PC+4 wraps from 0xFFFF_FFFC to 0
        jr = 1; jr_target = 32'hFFFF_FFFC; jump = 1; jump_target = 32'h300;
        #1 check("jr_flush_if", {31'd0, flush_if}, 32'd1);
        tick(); clear_inputs(); #1;
        check("jr_pc", PC, 32'hFFFF_FFFC);
        check("jr_kernel", {31'd0, kernel}, 32'd1);
        tick(); check("wrap_pc", PC, 32'h0);
        check("wrap_kernel", {31'd0, kernel}, 32'd0);
        tick(); check("wrap_pc4", PC, 32'h4);
        tick(); check("wrap_pc8", PC, 32'h8);

        // User-mode irq on a clean cycle is taken immediately
        irq = 1;
        #1 check("irq_now_ack", {31'd0, irq_ack}, 32'd1);
        tick(); irq = 0; #1;
        check("irq_now_pc", PC, 32'h8000_0008);
        check("irq_now_epc", epc, 32'h4);
        check("irq_now_ack_off", {31'd0, irq_ack}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: observed no completion, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
